traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/traffic_light_controller.sv | 152 +++++++++++++++
 tb/tb_traffic_light_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_controller.sv
// -----------------------------------------------------------------------------
// traffic_light_controller
//
// Purpose:
//   Three-phase traffic light sequencer (GREEN -> YELLOW -> RED -> GREEN)
//   with fixed phase durations and an optional pedestrian request that can
//   shorten green once a minimum green time has elapsed.
//
// Configuration macro:
//   PED_REQUEST_EN  - when defined, compiles in the pedestrian request latch
//                     and green shortening. When undefined, ped_req is
//                     ignored and ped_pending is held at 0.
//
// Parameters:
//   GREEN_CYCLES   green duration in clk cycles (1..65535)
//   YELLOW_CYCLES  yellow duration in clk cycles (1..65535)
//   RED_CYCLES     red duration in clk cycles (1..65535)
//   MIN_GREEN      green cycles required before a request may end green
//                  (1..GREEN_CYCLES)
//
// Ports:
//   clk           in   clock, rising-edge active
//   reset_n       in   asynchronous active-low reset (forces RED)
//   ped_req       in   pedestrian request, level or pulse
//   light         out  registered light code: 00 green, 01 yellow, 10 red
//   light_change  out  registered pulse in the first cycle of a new light
//   walk          out  registered, high while light is red
//   ped_pending   out  registered, high while a request waits to be served
// -----------------------------------------------------------------------------
module traffic_light_controller #(
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned RED_CYCLES    = 6,
  parameter int unsigned MIN_GREEN     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ped_req,
  output logic [1:0] light,
  output logic       light_change,
  output logic       walk,
  output logic       ped_pending
);

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } state_t;

  localparam logic [15:0] GREEN_LOAD  = 16'(GREEN_CYCLES - 1);
  localparam logic [15:0] YELLOW_LOAD = 16'(YELLOW_CYCLES - 1);
  localparam logic [15:0] RED_LOAD    = 16'(RED_CYCLES - 1);
  // In green cycle k the counter reads GREEN_CYCLES-k, so "at least
  // MIN_GREEN cycles elapsed" is the same as the counter being at or
  // below GREEN_CYCLES-MIN_GREEN.
  localparam logic [15:0] SHORT_LIMIT = 16'(GREEN_CYCLES - MIN_GREEN);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  light_q, light_d;
  logic        light_change_q, light_change_d;
  logic        walk_q, walk_d;
  logic        ped_pending_q, ped_pending_d;
  logic        ped_short;

`ifdef PED_REQUEST_EN
  // A request sampled on this edge counts as well as one already latched,
  // so a request arriving after the minimum green ends green immediately.
  assign ped_short = (state_q == GREEN) && (ped_pending_q || ped_req) &&
                     (cnt_q <= SHORT_LIMIT);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_short      = 1'b0;
`endif

  // Phase sequencing: the counter holds (duration-1) on entry and the phase
  // is left on the edge after it reaches 0, or early on pedestrian shortening.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 16'd1;
    case (state_q)
      GREEN: begin
        if (cnt_q == 16'd0 || ped_short) begin
          state_d = YELLOW;
          cnt_d   = YELLOW_LOAD;
        end
      end
      YELLOW: begin
        if (cnt_q == 16'd0) begin
          state_d = RED;
          cnt_d   = RED_LOAD;
        end
      end
      RED: begin
        if (cnt_q == 16'd0) begin
          state_d = GREEN;
          cnt_d   = GREEN_LOAD;
        end
      end
      default: begin
        state_d = RED;
        cnt_d   = RED_LOAD;
      end
    endcase
  end

  // Request latch: entering RED serves the request and wins over a new one.
  always_comb begin
    ped_pending_d = 1'b0;
`ifdef PED_REQUEST_EN
    ped_pending_d = ped_pending_q;
    if (state_q != RED && state_d == RED) begin
      ped_pending_d = 1'b0;
    end else if (state_q != RED && ped_req) begin
      ped_pending_d = 1'b1;
    end
`endif
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    light_d        = state_d;
    walk_d         = (state_d == RED);
    light_change_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RED;
      cnt_q          <= RED_LOAD;
      light_q        <= 2'b10;
      light_change_q <= 1'b0;
      walk_q         <= 1'b1;
      ped_pending_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      light_q        <= light_d;
      light_change_q <= light_change_d;
      walk_q         <= walk_d;
      ped_pending_q  <= ped_pending_d;
    end
  end

  assign light        = light_q;
  assign light_change = light_change_q;
  assign walk         = walk_q;
  assign ped_pending  = ped_pending_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_controller
//
// Purpose:
//   Self-checking bench for traffic_light_controller with default parameters.
//   A cycle model pushes the expected {light, light_change, walk, ped_pending}
//   into a queue each time stimulus is applied; the entry is popped and
//   compared once the DUT has clocked. Phase lengths are also checked against
//   fixed cycle counts. Pedestrian scenarios are built only when
//   PED_REQUEST_EN is defined, matching the DUT build.
// -----------------------------------------------------------------------------
module tb_traffic_light_controller;

  localparam int GREEN_LEN  = 8;
  localparam int YELLOW_LEN = 3;
  localparam int RED_LEN    = 6;
  localparam int MIN_GREEN  = 2;
`ifdef PED_REQUEST_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ped_req;
  logic [1:0] light;
  logic       light_change;
  logic       walk;
  logic       ped_pending;

  int check_count = 0;
  int error_count = 0;
  logic [4:0] exp_q[$];

  logic [1:0] m_light;
  int         m_elapsed;
  logic       m_pending;
  logic       m_change;

  traffic_light_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ped_req      (ped_req),
    .light        (light),
    .light_change (light_change),
    .walk         (walk),
    .ped_pending  (ped_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  function automatic int durationOf(input logic [1:0] l);
    case (l)
      2'b00:   return GREEN_LEN;
      2'b01:   return YELLOW_LEN;
      default: return RED_LEN;
    endcase
  endfunction

  task automatic modelReset();
    m_light   = 2'b10;
    m_elapsed = 1;
    m_pending = 1'b0;
    m_change  = 1'b0;
  endtask

  // Model counts elapsed cycles upward within each light.
  task automatic modelStep(input logic req);
    bit         leave;
    logic [1:0] nl;
    leave = (m_elapsed >= durationOf(m_light));
    if (PED && m_light == 2'b00 && m_elapsed >= MIN_GREEN && (m_pending || req))
      leave = 1'b1;
    if (!leave)                nl = m_light;
    else if (m_light == 2'b00) nl = 2'b01;
    else if (m_light == 2'b01) nl = 2'b10;
    else                       nl = 2'b00;
    if (PED) begin
      if (leave && nl == 2'b10)       m_pending = 1'b0;
      else if (m_light != 2'b10 && req) m_pending = 1'b1;
    end
    m_change  = leave;
    m_elapsed = leave ? 1 : m_elapsed + 1;
    m_light   = nl;
  endtask

  task automatic applyStimulus(input logic req);
    logic [4:0] expv;
    ped_req = req;
    modelStep(req);
    exp_q.push_back({m_light, m_change, (m_light == 2'b10), m_pending});
    @(posedge clk);
    #1;
    expv = exp_q.pop_front();
    checkOutput("cycle", {27'd0, light, light_change, walk, ped_pending},
                {27'd0, expv});
  endtask

  // Steps with a fixed request level until the DUT shows a new light, and
  // returns how many cycles the previous light lasted.
  task automatic measureRun(input logic req, input int start_len,
                            output int len);
    bit done;
    done = 1'b0;
    len  = start_len;
    for (int i = 0; i < 100 && !done; i++) begin
      applyStimulus(req);
      if (light_change) done = 1'b1;
      else              len++;
    end
    checkOutput("run_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic asyncReset();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_light",   {30'd0, light}, 32'h2);
    checkOutput("async_rst_walk",    {31'd0, walk}, 32'd1);
    checkOutput("async_rst_change",  {31'd0, light_change}, 32'd0);
    checkOutput("async_rst_pending", {31'd0, ped_pending}, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("rst_hold_light", {30'd0, light}, 32'h2);
    #2 reset_n = 1'b1;
  endtask

  // Main sequence: reset, fixed cycle, pedestrian scenarios, async reset.
  initial begin
    int len;
    bit found;
    reset_n = 1'b0;
    ped_req = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_light",   {30'd0, light}, 32'h2);
    checkOutput("rst_walk",    {31'd0, walk}, 32'd1);
    checkOutput("rst_change",  {31'd0, light_change}, 32'd0);
    checkOutput("rst_pending", {31'd0, ped_pending}, 32'd0);
    #2 reset_n = 1'b1;

    measureRun(1'b0, 1, len); checkOutput("first_red_len", len, RED_LEN);
    measureRun(1'b0, 1, len); checkOutput("green_len", len, GREEN_LEN);
    measureRun(1'b0, 1, len); checkOutput("yellow_len", len, YELLOW_LEN);
    measureRun(1'b0, 1, len); checkOutput("red_len", len, RED_LEN);

`ifdef PED_REQUEST_EN
    // Request in the 4th green cycle ends green after 4 cycles.
    repeat (3) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("ped4_yellow",  {30'd0, light}, 32'h1);
    checkOutput("ped4_pending", {31'd0, ped_pending}, 32'd1);
    measureRun(1'b0, 1, len); checkOutput("ped4_yellow_len", len, YELLOW_LEN);
    checkOutput("ped4_red_pending", {31'd0, ped_pending}, 32'd0);
    checkOutput("ped4_red_walk",    {31'd0, walk}, 32'd1);
    measureRun(1'b0, 1, len); checkOutput("ped4_red_len", len, RED_LEN);

    // Request in the 1st green cycle waits for the minimum green.
    applyStimulus(1'b1);
    measureRun(1'b0, 2, len); checkOutput("ped1_green_len", len, MIN_GREEN);
    measureRun(1'b0, 1, len); checkOutput("ped1_yellow_len", len, YELLOW_LEN);
    measureRun(1'b0, 1, len); checkOutput("ped1_red_len", len, RED_LEN);

    // Request held through red and into green, then through yellow into red.
    measureRun(1'b0, 1, len);
    measureRun(1'b0, 1, len);
    measureRun(1'b1, 1, len); checkOutput("held_red_len", len, RED_LEN);
    checkOutput("held_green1_pending", {31'd0, ped_pending}, 32'd0);
    applyStimulus(1'b1);
    checkOutput("held_latched", {31'd0, ped_pending}, 32'd1);
    measureRun(1'b1, 2, len); checkOutput("held_green_len", len, MIN_GREEN);
    measureRun(1'b1, 1, len); checkOutput("held_yellow_len", len, YELLOW_LEN);
    checkOutput("held_red_clear", {31'd0, ped_pending}, 32'd0);
    ped_req = 1'b0;
`else
    // Without the pedestrian feature a held request changes nothing.
    measureRun(1'b1, 1, len); checkOutput("noped_green_len", len, GREEN_LEN);
    measureRun(1'b1, 1, len); checkOutput("noped_yellow_len", len, YELLOW_LEN);
    measureRun(1'b1, 1, len); checkOutput("noped_red_len", len, RED_LEN);
    checkOutput("noped_pending", {31'd0, ped_pending}, 32'd0);
    ped_req = 1'b0;
`endif

    // Reset in the middle of yellow, then a full red period.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      applyStimulus(1'b0);
      if (light == 2'b01) found = 1'b1;
    end
    checkOutput("reach_yellow", {31'd0, found}, 32'd1);
    applyStimulus(1'b0);
    checkOutput("pre_reset_yellow", {30'd0, light}, 32'h1);
    asyncReset();
    measureRun(1'b0, 1, len); checkOutput("post_rst_red_len", len, RED_LEN);
    measureRun(1'b0, 1, len); checkOutput("post_rst_green_len", len, GREEN_LEN);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
